// File: rtl/t04_pkg.sv
// Shared types for the t04 operand-B select stage: source codes and skid-buffer states.
package t04_pkg;

    typedef enum logic [1:0] {
        OPB_REG     = 2'd0,
        OPB_IMM     = 2'd1,
        OPB_FWD_EX  = 2'd2,
        OPB_FWD_MEM = 2'd3
    } opsel_t;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } stage_state_t;

endpackage

// File: rtl/t04_skid_buf.sv
// Generic 2-entry valid/ready skid buffer. in_ready is a pure function of state,
// so there is no combinational path from out_ready back to in_ready.
module t04_skid_buf
    import t04_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);

    stage_state_t state_q, state_d;
    logic [W-1:0] main_q, main_d;
    logic [W-1:0] skid_q, skid_d;
    logic         accept;
    logic         transfer;

    assign in_ready  = (state_q != ST_FULL);
    assign out_valid = (state_q != ST_EMPTY);
    assign out_data  = main_q;
    assign accept    = in_valid & in_ready;
    assign transfer  = out_valid & out_ready;

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        if (flush) begin
            // Stale data is left in main/skid; out_valid=0 hides it.
            state_d = ST_EMPTY;
        end else begin
            unique case (state_q)
                ST_EMPTY: begin
                    if (accept) begin
                        main_d  = in_data;
                        state_d = ST_ONE;
                    end
                end
                ST_ONE: begin
                    if (accept && transfer) begin
                        main_d = in_data;
                    end else if (transfer) begin
                        state_d = ST_EMPTY;
                    end else if (accept) begin
                        skid_d  = in_data;
                        state_d = ST_FULL;
                    end
                end
                ST_FULL: begin
                    if (transfer) begin
                        main_d  = skid_q;
                        state_d = ST_ONE;
                    end
                end
                default: state_d = ST_EMPTY;
            endcase
        end
    end

    // NOTE: state uses non-blocking assignments only; blocking here would race with readers in other always blocks.
    // NOTE: the data registers are reset too, so op_out reads 0 straight out of reset rather than X.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_EMPTY;
            main_q  <= '0;
            skid_q  <= '0;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
        end
    end

endmodule

// File: rtl/t04_operand_sel_stage.sv
// ALU operand-B selector: combinational source mux in front of a skid buffer
// carrying {err, data}; one cycle of latency at full throughput.
module t04_operand_sel_stage
    import t04_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int NSRC  = 4,
    parameter int SELW  = $clog2(NSRC)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [SELW-1:0]       sel,
    input  logic [NSRC*WIDTH-1:0] src_bus,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [WIDTH-1:0]      op_out,
    output logic                  sel_err
);

    logic [WIDTH-1:0] sel_data;
    logic             sel_bad;
    logic [WIDTH:0]   buf_out;

    // Codes with no matching source (NSRC not a power of 2) fall through to data 0, err 1.
    always_comb begin
        sel_data = '0;
        sel_bad  = 1'b1;
        for (int i = 0; i < NSRC; i++) begin
            if (sel == SELW'(i)) begin
                sel_data = src_bus[i*WIDTH +: WIDTH];
                sel_bad  = 1'b0;
            end
        end
    end

    t04_skid_buf #(
        .W(WIDTH + 1)
    ) u_skid (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   ({sel_bad, sel_data}),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (buf_out)
    );

    assign {sel_err, op_out} = buf_out;

endmodule

// File: tb/tb_t04_operand_sel_stage.sv
// Directed and randomized checks of the operand-B select stage (three parameter sets).
module tb_t04_operand_sel_stage;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Instance A: WIDTH=32, NSRC=4
    logic         a_flush, a_in_valid, a_out_ready;
    logic [1:0]   a_sel;
    logic [127:0] a_src;
    logic         a_in_ready, a_out_valid, a_sel_err;
    logic [31:0]  a_op;

    // Instance B: WIDTH=32, NSRC=3
    logic         b_flush, b_in_valid, b_out_ready;
    logic [1:0]   b_sel;
    logic [95:0]  b_src;
    logic         b_in_ready, b_out_valid, b_sel_err;
    logic [31:0]  b_op;

    // Instance C: WIDTH=16, NSRC=5
    logic         c_flush, c_in_valid, c_out_ready;
    logic [2:0]   c_sel;
    logic [79:0]  c_src;
    logic         c_in_ready, c_out_valid, c_sel_err;
    logic [15:0]  c_op;

    t04_operand_sel_stage #(.WIDTH(32), .NSRC(4)) u_dut_a (
        .clk(clk), .rst(rst), .flush(a_flush), .in_valid(a_in_valid), .in_ready(a_in_ready),
        .sel(a_sel), .src_bus(a_src), .out_valid(a_out_valid), .out_ready(a_out_ready),
        .op_out(a_op), .sel_err(a_sel_err)
    );

    t04_operand_sel_stage #(.WIDTH(32), .NSRC(3)) u_dut_b (
        .clk(clk), .rst(rst), .flush(b_flush), .in_valid(b_in_valid), .in_ready(b_in_ready),
        .sel(b_sel), .src_bus(b_src), .out_valid(b_out_valid), .out_ready(b_out_ready),
        .op_out(b_op), .sel_err(b_sel_err)
    );

    t04_operand_sel_stage #(.WIDTH(16), .NSRC(5)) u_dut_c (
        .clk(clk), .rst(rst), .flush(c_flush), .in_valid(c_in_valid), .in_ready(c_in_ready),
        .sel(c_sel), .src_bus(c_src), .out_valid(c_out_valid), .out_ready(c_out_ready),
        .op_out(c_op), .sel_err(c_sel_err)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_b(input string tag, input logic obs, input logic exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    // Inputs change and outputs are sampled on the falling edge.
    task automatic step();
        @(negedge clk);
    endtask

    initial begin
        logic [16:0] q[$];
        logic [16:0] exp_c;
        logic        push_ok, pop_ok;
        int          s, fail_snap;

        a_flush = 0; a_in_valid = 0; a_out_ready = 0; a_sel = 0; a_src = '0;
        b_flush = 0; b_in_valid = 0; b_out_ready = 0; b_sel = 0; b_src = '0;
        c_flush = 0; c_in_valid = 0; c_out_ready = 0; c_sel = 0; c_src = '0;

        // ---- 1: reset ----
        repeat (2) step();
        rst = 1'b0;
        check_b("t1_rst_out_valid", a_out_valid, 1'b0);
        check_b("t1_rst_in_ready", a_in_ready, 1'b1);
        check("t1_rst_op", a_op, 32'h0);
        check_b("t1_rst_sel_err", a_sel_err, 1'b0);
        check_b("t1_rst_b_out_valid", b_out_valid, 1'b0);
        check_b("t1_rst_c_out_valid", c_out_valid, 1'b0);

        a_in_valid = 1; a_sel = 2'd1; a_src[63:32] = 32'h77;
        step();
        a_src[63:32] = 32'h78;
        step();
        a_in_valid = 0;
        check_b("t1_full_in_ready", a_in_ready, 1'b0);
        check("t1_full_op", a_op, 32'h77);
        rst = 1'b1;
        #1;
        check_b("t1_midrst_out_valid", a_out_valid, 1'b0);
        check_b("t1_midrst_in_ready", a_in_ready, 1'b1);
        check("t1_midrst_op", a_op, 32'h0);
        step(); step();
        rst = 1'b0;
        step();
        check_b("t1_post_out_valid", a_out_valid, 1'b0);
        check_b("t1_post_in_ready", a_in_ready, 1'b1);
        check("t1_post_op", a_op, 32'h0);

        // ---- 2: streaming ----
        a_out_ready = 1; a_sel = 2'd1;
        for (int k = 0; k < 8; k++) begin
            a_in_valid = 1;
            a_src[63:32] = 32'h11 + 32'(k);
            step();
            check_b("t2_out_valid", a_out_valid, 1'b1);
            check("t2_op", a_op, 32'h11 + 32'(k));
            check_b("t2_in_ready", a_in_ready, 1'b1);
        end
        a_in_valid = 0;
        step();
        check_b("t2_drained", a_out_valid, 1'b0);

        // ---- 3: backpressure ----
        a_out_ready = 0; a_in_valid = 1; a_src[63:32] = 32'hA5A5A5A5;
        step();
        check("t3_a_held", a_op, 32'hA5A5A5A5);
        check_b("t3_one_in_ready", a_in_ready, 1'b1);
        a_src[63:32] = 32'h5A5A5A5A;
        step();
        a_in_valid = 0;
        check_b("t3_full_in_ready", a_in_ready, 1'b0);
        check("t3_full_op", a_op, 32'hA5A5A5A5);
        step();
        check("t3_stall_stable", a_op, 32'hA5A5A5A5);
        check_b("t3_stall_valid", a_out_valid, 1'b1);
        a_out_ready = 1;
        step();
        check("t3_second", a_op, 32'h5A5A5A5A);
        check_b("t3_second_valid", a_out_valid, 1'b1);
        step();
        check_b("t3_empty", a_out_valid, 1'b0);

        // ---- 4: select sweep ----
        a_src = {32'h400, 32'h300, 32'h200, 32'h100};
        for (int k = 0; k < 4; k++) begin
            a_in_valid = 1;
            a_sel = 2'(k);
            step();
            check("t4_sweep_op", a_op, 32'((k + 1) * 256));
            check_b("t4_sweep_err", a_sel_err, 1'b0);
        end
        a_in_valid = 0;
        step();

        b_src = {32'h300, 32'h200, 32'h100};
        b_out_ready = 1; b_in_valid = 1; b_sel = 2'd3;
        step();
        check_b("t4_nsrc3_valid", b_out_valid, 1'b1);
        check("t4_nsrc3_bad_op", b_op, 32'h0);
        check_b("t4_nsrc3_bad_err", b_sel_err, 1'b1);
        b_sel = 2'd2;
        step();
        check("t4_nsrc3_op2", b_op, 32'h300);
        check_b("t4_nsrc3_err2", b_sel_err, 1'b0);
        b_in_valid = 0;
        step();
        check_b("t4_nsrc3_drained", b_out_valid, 1'b0);

        // ---- 5: flush ----
        a_out_ready = 0; a_sel = 2'd1; a_src = '0;
        a_in_valid = 1; a_src[63:32] = 32'hAAAA0001;
        step();
        a_src[63:32] = 32'hAAAA0002;
        step();
        check_b("t5_full_in_ready", a_in_ready, 1'b0);
        a_flush = 1; a_src[63:32] = 32'hDEADBEEF;
        step();
        a_flush = 0; a_in_valid = 0;
        check_b("t5_flush_out_valid", a_out_valid, 1'b0);
        check_b("t5_flush_in_ready", a_in_ready, 1'b1);
        a_out_ready = 1;
        step();
        check_b("t5_flush_stays_empty", a_out_valid, 1'b0);

        a_out_ready = 0; a_in_valid = 1; a_src[63:32] = 32'h0000BEEF;
        step();
        a_flush = 1; a_src[63:32] = 32'hCAFE0000;
        step();
        a_flush = 0;
        check_b("t5_one_flush_valid", a_out_valid, 1'b0);
        a_src[63:32] = 32'h1234;
        step();
        a_in_valid = 0;
        check_b("t5_after_valid", a_out_valid, 1'b1);
        check("t5_after_op", a_op, 32'h1234);
        a_out_ready = 1;
        step();
        check_b("t5_after_drained", a_out_valid, 1'b0);

        // ---- 6: random valid/ready vs occupancy queue ----
        fail_snap = n_fail;
        for (int cyc = 0; cyc < 10000 && (n_fail - fail_snap) < 10; cyc++) begin
            check_b("t6_out_valid", c_out_valid, q.size() != 0);
            check_b("t6_in_ready", c_in_ready, q.size() < 2);
            if (q.size() != 0)
                check("t6_head", 32'({c_sel_err, c_op}), 32'(q[0]));

            c_in_valid  = ($urandom_range(0, 99) < 60);
            c_out_ready = ($urandom_range(0, 99) < 60);
            c_flush     = ($urandom_range(0, 127) == 0);
            c_sel       = 3'($urandom_range(0, 7));
            for (int j = 0; j < 5; j++)
                c_src[j*16 +: 16] = 16'($urandom);

            if (c_flush) begin
                q.delete();
            end else begin
                s = int'(c_sel);
                exp_c   = (s < 5) ? {1'b0, c_src[s*16 +: 16]} : {1'b1, 16'h0};
                push_ok = c_in_valid && (q.size() < 2);
                pop_ok  = c_out_ready && (q.size() != 0);
                if (pop_ok)  void'(q.pop_front());
                if (push_ok) q.push_back(exp_c);
            end
            step();
        end
        c_in_valid = 0; c_out_ready = 0; c_flush = 0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
